// File: rtl/dac_frame_scheduler_if.sv
// Sample-requester and DAC-driver handshake bundle.
// master: the scheduler; slave: the requesters and the DAC driver.
interface dac_frame_scheduler_if;
    logic        req_a;
    logic [11:0] va_a;
    logic [11:0] vb_a;
    logic        ack_a;
    logic        req_b;
    logic [11:0] va_b;
    logic [11:0] vb_b;
    logic        ack_b;
    logic        dac_busy;
    logic        dac_start;
    logic [11:0] dac_va;
    logic [11:0] dac_vb;
    logic        owner_b;

    modport master (
        input  req_a, va_a, vb_a,
        input  req_b, va_b, vb_b,
        input  dac_busy,
        output ack_a, ack_b,
        output dac_start, dac_va, dac_vb, owner_b
    );

    modport slave (
        output req_a, va_a, vb_a,
        output req_b, va_b, vb_b,
        output dac_busy,
        input  ack_a, ack_b,
        input  dac_start, dac_va, dac_vb, owner_b
    );
endinterface

// File: rtl/dac_frame_scheduler.sv
// Frame-rate scheduler for the dual-channel SPI DAC driver.
// Round-robin between two sample sources, busy supervision.
module dac_frame_scheduler #(
    parameter int unsigned SAMPLE_DIV   = 1000,
    parameter int unsigned BUSY_TIMEOUT = 4000,
    parameter int unsigned START_WINDOW = 8
) (
    input  logic                  qzt_clk,
    input  logic                  reset_n,
    input  logic                  enable,
    dac_frame_scheduler_if.master bus,
    output logic                  frame_tick,
    output logic [7:0]            missed_frames,
    output logic                  timeout_err
);

    localparam int unsigned TMR_MAX =
        (BUSY_TIMEOUT > START_WINDOW) ? BUSY_TIMEOUT : START_WINDOW;
    localparam int TMR_W = $clog2(TMR_MAX + 1);

    localparam logic [15:0]      DIV_LAST = 16'(SAMPLE_DIV - 1);
    localparam logic [TMR_W-1:0] SW_LAST  = TMR_W'(START_WINDOW - 1);
    localparam logic [TMR_W-1:0] BT_LAST  = TMR_W'(BUSY_TIMEOUT - 1);
    localparam logic [11:0]      MID      = 12'h800;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_BUSY,
        WAIT_DONE
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [15:0]      div_q;
    logic [TMR_W-1:0] tmr_q;
    logic [TMR_W-1:0] tmr_d;
    logic             to_set;
    logic             ptr_b;
    logic             owner_q;
    logic [11:0]      va_q;
    logic [11:0]      vb_q;
    logic             grant_a;
    logic             grant_b;
    logic             granted;
    logic [11:0]      sel_va;
    logic [11:0]      sel_vb;
    logic [11:0]      new_va;
    logic [11:0]      new_vb;

    // Frame divider; a low enable parks it at 0 so no ticks are produced
    always_ff @(posedge qzt_clk or negedge reset_n) begin
        if (!reset_n) begin
            div_q      <= '0;
            frame_tick <= 1'b0;
        end else if (!enable) begin
            div_q      <= '0;
            frame_tick <= 1'b0;
        end else if (div_q == DIV_LAST) begin
            div_q      <= '0;
            frame_tick <= 1'b1;
        end else begin
            div_q      <= div_q + 16'd1;
            frame_tick <= 1'b0;
        end
    end

    // Round-robin arbiter, only looks at the requests during ISSUE
    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        if (state_q == ISSUE) begin
            unique case (1'b1)
                (bus.req_a && bus.req_b): begin
                    grant_a = !ptr_b;
                    grant_b = ptr_b;
                end
                (bus.req_a && !bus.req_b): grant_a = 1'b1;
                (!bus.req_a && bus.req_b): grant_b = 1'b1;
                default: ;
            endcase
        end
    end

    // Offset-binary conversion of the granted pair: flip the sign bit
    always_comb begin
        sel_va  = grant_b ? bus.va_b : bus.va_a;
        sel_vb  = grant_b ? bus.vb_b : bus.vb_a;
        new_va  = {~sel_va[11], sel_va[10:0]};
        new_vb  = {~sel_vb[11], sel_vb[10:0]};
        granted = grant_a | grant_b;
    end

    // Driver-facing outputs; new words appear in the ISSUE cycle itself
    always_comb begin
        bus.dac_start = (state_q == ISSUE);
        bus.ack_a     = grant_a;
        bus.ack_b     = grant_b;
        bus.dac_va    = granted ? new_va  : va_q;
        bus.dac_vb    = granted ? new_vb  : vb_q;
        bus.owner_b   = granted ? grant_b : owner_q;
    end

    // Hold the last granted words and owner until the next grant
    always_ff @(posedge qzt_clk or negedge reset_n) begin
        if (!reset_n) begin
            va_q    <= MID;
            vb_q    <= MID;
            owner_q <= 1'b0;
            ptr_b   <= 1'b0;
        end else if (granted) begin
            va_q    <= new_va;
            vb_q    <= new_vb;
            owner_q <= grant_b;
            ptr_b   <= grant_a;
        end
    end

    // Next-state logic; tmr counts cycles since dac_start
    always_comb begin
        state_d = state_q;
        tmr_d   = tmr_q;
        to_set  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (frame_tick) begin
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                state_d = WAIT_BUSY;
                tmr_d   = TMR_W'(1);
            end
            WAIT_BUSY: begin
                tmr_d = tmr_q + TMR_W'(1);
                if (bus.dac_busy) begin
                    state_d = WAIT_DONE;
                end else if (tmr_q >= SW_LAST) begin
                    state_d = IDLE;
                    to_set  = 1'b1;
                end
            end
            WAIT_DONE: begin
                tmr_d = tmr_q + TMR_W'(1);
                if (!bus.dac_busy) begin
                    state_d = IDLE;
                end else if (tmr_q >= BT_LAST) begin
                    state_d = IDLE;
                    to_set  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and transaction timer registers
    always_ff @(posedge qzt_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            tmr_q   <= '0;
        end else begin
            state_q <= state_d;
            tmr_q   <= tmr_d;
        end
    end

    // Sticky status: timeouts and ticks lost while not idle
    always_ff @(posedge qzt_clk or negedge reset_n) begin
        if (!reset_n) begin
            timeout_err   <= 1'b0;
            missed_frames <= 8'd0;
        end else begin
            if (to_set) begin
                timeout_err <= 1'b1;
            end
            if (frame_tick && state_q != IDLE &&
                missed_frames != 8'hFF) begin
                missed_frames <= missed_frames + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_dac_frame_scheduler.sv
// Scoreboard bench for dac_frame_scheduler.
// Expected frames are queued with stimulus, popped at dac_start.
module tb_dac_frame_scheduler;

    localparam int SD = 32;
    localparam int SW = 8;
    localparam int BT = 80;

    typedef struct packed {
        logic        ack_a;
        logic        ack_b;
        logic        owner_b;
        logic [11:0] va;
        logic [11:0] vb;
    } exp_t;

    logic       qzt_clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       enable = 1'b0;
    logic       frame_tick;
    logic [7:0] missed_frames;
    logic       timeout_err;
    logic       busy_force = 1'b0;
    logic       busy_pulse = 1'b0;
    logic       prev_tick = 1'b0;

    int   busy_len = 10;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;
    int   last_start = 0;
    int   n_start = 0;
    bit   sb_on = 1'b0;
    bit   spacing_on = 1'b0;
    bit   have_prev = 1'b0;
    exp_t sb_q[$];
    exp_t mon_e;
    int   s;
    int   s2;
    int   n0;

    dac_frame_scheduler_if bus();

    assign bus.dac_busy = busy_force | busy_pulse;

    dac_frame_scheduler #(
        .SAMPLE_DIV  (SD),
        .BUSY_TIMEOUT(BT),
        .START_WINDOW(SW)
    ) u_dut (
        .qzt_clk      (qzt_clk),
        .reset_n      (reset_n),
        .enable       (enable),
        .bus          (bus),
        .frame_tick   (frame_tick),
        .missed_frames(missed_frames),
        .timeout_err  (timeout_err)
    );

    always #5 qzt_clk = ~qzt_clk;

    always @(posedge qzt_clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic settle();
        @(negedge qzt_clk);
        #1;
    endtask

    task automatic wait_cyc(input int target);
        while (cyc < target) @(negedge qzt_clk);
    endtask

    task automatic drain(input string tag, input int max_cyc);
        int t0;
        t0 = cyc;
        while (sb_q.size() != 0 && cyc < t0 + max_cyc) settle();
        chk(tag, 32'(sb_q.size()), 32'd0);
    endtask

    task automatic wait_start(input string tag, input int max_cyc,
                              output int st);
        int c0;
        int k0;
        c0 = cyc;
        k0 = n_start;
        while (n_start == k0 && cyc < c0 + max_cyc) settle();
        chk(tag, 32'(n_start != k0), 32'd1);
        st = last_start;
    endtask

    task automatic rst_assert();
        @(negedge qzt_clk);
        reset_n = 1'b0;
        sb_q.delete();
        have_prev = 1'b0;
        #1;
    endtask

    task automatic rst_release();
        repeat (2) @(negedge qzt_clk);
        reset_n = 1'b1;
        #1;
    endtask

    task automatic push(input logic aa, input logic ab, input logic ow,
                        input logic [11:0] va, input logic [11:0] vb);
        exp_t e;
        e.ack_a   = aa;
        e.ack_b   = ab;
        e.owner_b = ow;
        e.va      = va;
        e.vb      = vb;
        sb_q.push_back(e);
    endtask

    // Simple driver model: busy rises with dac_start for busy_len cycles
    initial begin
        forever begin
            @(negedge qzt_clk);
            if (bus.dac_start && busy_len > 0) begin
                busy_pulse = 1'b1;
                repeat (busy_len) @(negedge qzt_clk);
                busy_pulse = 1'b0;
            end
        end
    end

    // Monitor: pops one expected frame per dac_start
    initial begin
        forever begin
            @(negedge qzt_clk);
            if (bus.dac_start) begin
                if (sb_on) begin
                    chk("tick_then_start", 32'(prev_tick), 32'd1);
                    if (spacing_on && have_prev)
                        chk("frame_spacing", 32'(cyc - last_start), 32'(SD));
                    if (sb_q.size() == 0) begin
                        chk("sb_underflow", 32'(sb_q.size()), 32'd1);
                    end else begin
                        mon_e = sb_q.pop_front();
                        chk("ack_a", 32'(bus.ack_a), 32'(mon_e.ack_a));
                        chk("ack_b", 32'(bus.ack_b), 32'(mon_e.ack_b));
                        chk("owner_b", 32'(bus.owner_b), 32'(mon_e.owner_b));
                        chk("dac_va", 32'(bus.dac_va), 32'(mon_e.va));
                        chk("dac_vb", 32'(bus.dac_vb), 32'(mon_e.vb));
                    end
                end
                have_prev  = 1'b1;
                last_start = cyc;
                n_start++;
            end else if (bus.ack_a || bus.ack_b) begin
                chk("stray_ack", 32'({bus.ack_a, bus.ack_b}), 32'd0);
            end
            prev_tick = frame_tick;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.req_a = 1'b1;
        bus.va_a  = 12'h7FF;
        bus.vb_a  = 12'h001;
        bus.req_b = 1'b0;
        bus.va_b  = 12'h000;
        bus.vb_b  = 12'h000;

        // Reset values with a request already pending
        repeat (2) @(negedge qzt_clk);
        chk("rst_dac_va", 32'(bus.dac_va), 32'h800);
        chk("rst_dac_vb", 32'(bus.dac_vb), 32'h800);
        chk("rst_dac_start", 32'(bus.dac_start), 32'd0);
        chk("rst_ack_a", 32'(bus.ack_a), 32'd0);
        chk("rst_owner_b", 32'(bus.owner_b), 32'd0);
        chk("rst_tick", 32'(frame_tick), 32'd0);
        chk("rst_missed", 32'(missed_frames), 32'd0);
        chk("rst_timeout", 32'(timeout_err), 32'd0);

        // First frame grants A, 7FF becomes FFF
        sb_on = 1'b1;
        push(1'b1, 1'b0, 1'b0, 12'hFFF, 12'h801);
        @(negedge qzt_clk);
        reset_n = 1'b1;
        enable  = 1'b1;
        drain("t1_drain", 3 * SD);
        settle();
        chk("t1_hold_va", 32'(bus.dac_va), 32'hFFF);
        sb_on     = 1'b0;
        bus.req_a = 1'b0;

        // Both requesting: A, B, A, B at exact frame spacing
        rst_assert();
        bus.req_a = 1'b1;
        bus.va_a  = 12'h123;
        bus.vb_a  = 12'hF00;
        bus.req_b = 1'b1;
        bus.va_b  = 12'h800;
        bus.vb_b  = 12'h7FF;
        push(1'b1, 1'b0, 1'b0, 12'h923, 12'h700);
        push(1'b0, 1'b1, 1'b1, 12'h000, 12'hFFF);
        push(1'b1, 1'b0, 1'b0, 12'h923, 12'h700);
        push(1'b0, 1'b1, 1'b1, 12'h000, 12'hFFF);
        sb_on      = 1'b1;
        spacing_on = 1'b1;
        rst_release();
        drain("t2_drain", 5 * SD);
        settle();
        sb_on     = 1'b0;
        bus.req_a = 1'b0;
        bus.req_b = 1'b0;

        // Grant 555 once, then refresh frames with no requester
        bus.req_a = 1'b1;
        bus.va_a  = 12'hD55;
        bus.vb_a  = 12'h2AA;
        push(1'b1, 1'b0, 1'b0, 12'h555, 12'hAAA);
        sb_on = 1'b1;
        drain("t3_grant", 2 * SD);
        settle();
        bus.req_a = 1'b0;
        for (int i = 0; i < 3; i++)
            push(1'b0, 1'b0, 1'b0, 12'h555, 12'hAAA);
        drain("t3_refresh", 4 * SD);
        settle();
        chk("t3_hold_va", 32'(bus.dac_va), 32'h555);
        sb_on = 1'b0;

        // Enable low: no frames at all
        enable = 1'b0;
        n0 = n_start;
        wait_cyc(cyc + 3 * SD);
        chk("en_low_starts", 32'(n_start - n0), 32'd0);
        have_prev = 1'b0;
        enable    = 1'b1;

        // Busy never rises: start-window timeout, next frame still issues
        busy_len  = 0;
        bus.req_b = 1'b1;
        bus.va_b  = 12'h001;
        bus.vb_b  = 12'hFFF;
        push(1'b0, 1'b1, 1'b1, 12'h801, 12'h7FF);
        sb_on = 1'b1;
        drain("t4_grant", 2 * SD);
        s = last_start;
        settle();
        bus.req_b = 1'b0;
        wait_cyc(s + SW - 1);
        chk("t4_err_early", 32'(timeout_err), 32'd0);
        wait_cyc(s + SW);
        chk("t4_err_set", 32'(timeout_err), 32'd1);
        push(1'b0, 1'b0, 1'b1, 12'h801, 12'h7FF);
        drain("t4_next", 2 * SD);
        chk("t4_err_sticky", 32'(timeout_err), 32'd1);
        chk("t4_no_miss", 32'(missed_frames), 32'd0);
        sb_on    = 1'b0;
        busy_len = 10;

        // Overrun: busy ends on a tick cycle, then a long busy times out
        rst_assert();
        busy_len = 2 * SD - 1;
        rst_release();
        wait_start("t5_start", 2 * SD, s);
        wait_cyc(s + 70);
        chk("t5_missed2", 32'(missed_frames), 32'd2);
        chk("t5_no_err", 32'(timeout_err), 32'd0);
        busy_len = 90;
        wait_start("t5_start2", 2 * SD, s2);
        chk("t5_gap", 32'(s2 - s), 32'(3 * SD));
        wait_cyc(s2 + BT - 1);
        chk("t5_err_early", 32'(timeout_err), 32'd0);
        wait_cyc(s2 + BT);
        chk("t5_err_set", 32'(timeout_err), 32'd1);
        chk("t5_missed4", 32'(missed_frames), 32'd4);

        // Permanent busy: misses saturate at 255
        busy_force = 1'b1;
        wait_cyc(cyc + 15000);
        chk("t5_saturate", 32'(missed_frames), 32'd255);
        busy_force = 1'b0;
        busy_len   = 40;

        // Reset during WAIT_DONE, then frames resume
        rst_assert();
        bus.req_a = 1'b1;
        bus.va_a  = 12'h100;
        bus.vb_a  = 12'hE00;
        push(1'b1, 1'b0, 1'b0, 12'h900, 12'h600);
        sb_on      = 1'b1;
        spacing_on = 1'b0;
        rst_release();
        drain("t6_grant", 2 * SD);
        s = last_start;
        wait_cyc(s + 10);
        chk("t6_pre_va", 32'(bus.dac_va), 32'h900);
        #1;
        reset_n = 1'b0;
        sb_q.delete();
        #1;
        chk("t6_rst_va", 32'(bus.dac_va), 32'h800);
        chk("t6_rst_vb", 32'(bus.dac_vb), 32'h800);
        chk("t6_rst_start", 32'(bus.dac_start), 32'd0);
        chk("t6_rst_ack", 32'(bus.ack_a), 32'd0);
        chk("t6_rst_missed", 32'(missed_frames), 32'd0);
        push(1'b1, 1'b0, 1'b0, 12'h900, 12'h600);
        rst_release();
        drain("t6_resume", 3 * SD);
        sb_on = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
